// File: rtl/cpu_trace_tx.sv
// cpu_trace_tx: captures a data_path register/memory snapshot on a snap strobe
// and sends it as one framed 8N1 UART byte stream.
// Frame: sync 0xA5, 14 words MSB-byte first, XOR checksum of the payload bytes.
module cpu_trace_tx #(
   parameter int DW           = 16,
   parameter int CLKS_PER_BIT = 868
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             snap,
   input  logic [14*DW-1:0] snap_data,
   output logic             txd,
   output logic             busy,
   output logic [7:0]       drop_cnt
);

   localparam int BPW = DW / 8;          // bytes per traced word
   localparam int NPL = 14 * BPW;        // payload bytes
   localparam int NB  = NPL + 2;         // sync + payload + checksum
   localparam int TW  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BIW = $clog2(NB);

   localparam logic [TW-1:0]  TMAX  = TW'(CLKS_PER_BIT - 1);
   localparam logic [BIW-1:0] LASTB = BIW'(NB - 1);
   localparam logic [7:0]     SYNC  = 8'hA5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t            state;
   logic [TW-1:0]     timer;
   logic [2:0]        bit_idx;
   logic [BIW-1:0]    byte_idx;
   logic [7:0]        shreg;
   logic [7:0]        chk;
   logic [7:0]        shadow [NPL];

   logic              accept;
   logic              bit_end;
   logic              last_byte;
   logic              next_is_chk;

   // Qualifiers shared by the capture and transmit logic.
   always_comb begin
      accept      = snap && !busy;
      bit_end     = (timer == TMAX);
      last_byte   = (byte_idx == LASTB);
      next_is_chk = (byte_idx == BIW'(NB - 2));
   end

   // Shadow buffer in transmit order, so the serialiser just walks it by byte index.
   always_ff @(posedge clk) begin
      if (!rst && accept) begin
         for (int p = 0; p < NPL; p++) begin
            shadow[p] <= snap_data[(p / BPW) * DW + (BPW - 1 - (p % BPW)) * 8 +: 8];
         end
      end
   end

   // Rejected-snap counter; saturates so a stuck snap line cannot wrap it.
   always_ff @(posedge clk) begin
      if (rst) begin
         drop_cnt <= 8'd0;
      end else if (snap && busy && (drop_cnt != 8'hFF)) begin
         drop_cnt <= drop_cnt + 8'd1;
      end
   end

   // Transmit FSM: bit timer, bit/byte indices, running checksum, registered txd/busy.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         txd      <= 1'b1;
         busy     <= 1'b0;
         timer    <= '0;
         bit_idx  <= 3'd0;
         byte_idx <= '0;
         chk      <= 8'd0;
      end else begin
         case (state)
            IDLE: begin
               txd  <= 1'b1;
               busy <= 1'b0;
               if (snap) begin
                  state    <= START;
                  txd      <= 1'b0;
                  busy     <= 1'b1;
                  timer    <= '0;
                  byte_idx <= '0;
                  chk      <= 8'd0;
                  shreg    <= SYNC;
               end
            end

            START: begin
               if (bit_end) begin
                  timer   <= '0;
                  bit_idx <= 3'd0;
                  state   <= DATA;
                  txd     <= shreg[0];
               end else begin
                  timer <= timer + 1'b1;
               end
            end

            DATA: begin
               if (bit_end) begin
                  timer <= '0;
                  if (bit_idx == 3'd7) begin
                     state <= STOP;
                     txd   <= 1'b1;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     txd     <= shreg[1];
                     shreg   <= {1'b0, shreg[7:1]};
                  end
               end else begin
                  timer <= timer + 1'b1;
               end
            end

            STOP: begin
               if (bit_end) begin
                  timer <= '0;
                  if (last_byte) begin
                     // Frame done: busy drops at the edge the last stop bit ends.
                     state <= IDLE;
                     busy  <= 1'b0;
                     txd   <= 1'b1;
                  end else begin
                     // Next start bit follows the stop bit with no idle gap.
                     state    <= START;
                     txd      <= 1'b0;
                     byte_idx <= byte_idx + 1'b1;
                     if (next_is_chk) begin
                        shreg <= chk;
                     end else begin
                        // Payload byte n lives at shadow[n-1]; fold it into the checksum as it loads.
                        shreg <= shadow[byte_idx];
                        chk   <= chk ^ shadow[byte_idx];
                     end
                  end
               end else begin
                  timer <= timer + 1'b1;
               end
            end

            default: begin
               state <= IDLE;
               txd   <= 1'b1;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
